// File: rtl/lstm_pkg.sv
// Shared fixed-point types and arithmetic for the LSTM cell-update pipeline.
// All values are signed Q15.16 unless noted.
package lstm_pkg;
  typedef logic signed [31:0] fx_t;

  localparam int  LSTM_N  = 100;
  localparam int  FRAC    = 16;
  localparam fx_t FX_ONE  = fx_t'(1) <<< FRAC;
  localparam fx_t FX_HALF = FX_ONE >>> 1;

  // Gate index into the pre-activation vector; word offset is gate*N.
  localparam int GATE_I = 0;
  localparam int GATE_F = 1;
  localparam int GATE_G = 2;
  localparam int GATE_O = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  typedef struct packed {
    fx_t si;
    fx_t sf;
    fx_t tg;
    fx_t so;
  } act_t;

  function automatic fx_t sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF)      return 32'sh7FFF_FFFF;
    else if (v < 64'shFFFF_FFFF_8000_0000) return 32'sh8000_0000;
    else                                   return fx_t'(v[31:0]);
  endfunction

  function automatic logic signed [63:0] mul_shr(input fx_t a, input fx_t b);
    logic signed [63:0] aa;
    logic signed [63:0] bb;
    aa = a;
    bb = b;
    return (aa * bb) >>> FRAC;
  endfunction

  function automatic fx_t fx_mul(input fx_t a, input fx_t b);
    return sat32(mul_shr(a, b));
  endfunction

  function automatic fx_t hsig(input fx_t x);
    fx_t t;
    t = (x >>> 2) + FX_HALF;
    if (t < 0)      return '0;
    if (t > FX_ONE) return FX_ONE;
    return t;
  endfunction

  function automatic fx_t htanh(input fx_t x);
    if (x > FX_ONE)  return FX_ONE;
    if (x < -FX_ONE) return -FX_ONE;
    return x;
  endfunction
endpackage

// File: rtl/lstm_cell_update_act.sv
// Combinational S1 activations for one unit: hard-sigmoid on i/f/o,
// hard-tanh on the candidate g.
module lstm_act_unit
  import lstm_pkg::*;
(
  input  fx_t  i_a_i,
  input  fx_t  i_a_f,
  input  fx_t  i_a_g,
  input  fx_t  i_a_o,
  output act_t o_act
);
  assign o_act.si = hsig(i_a_i);
  assign o_act.sf = hsig(i_a_f);
  assign o_act.tg = htanh(i_a_g);
  assign o_act.so = hsig(i_a_o);
endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell update: streams N units through activation, cell update and
// output stages, holding c across timesteps.
module lstm_cell_update
  import lstm_pkg::*;
#(
  parameter int N = LSTM_N
) (
  input  logic clk,
  input  logic rst_n,
  input  fx_t  A [0:4*N-1],
  input  logic start,
  input  logic clear_state,
  output logic busy,
  output logic done,
  output fx_t  h [0:N-1],
  output fx_t  c [0:N-1]
);
  localparam int KW = $clog2(N);
  localparam int AW = KW + 2;

  state_e          r_state, w_state_nxt;
  logic [KW-1:0]   r_k, r_k1, r_k2;
  logic [3:1]      r_vld_pipe;
  logic            r_last3, r_done;
  logic            w_issue, w_last_out;
  act_t            w_act, r_act;
  fx_t             r_cn, r_so2, w_cn;
  fx_t             r_c [0:N-1];
  fx_t             r_h [0:N-1];
  logic [AW-1:0]   w_idx_i, w_idx_f, w_idx_g, w_idx_o;
  logic signed [63:0] w_sum;

  assign w_idx_i = AW'(GATE_I * N) + AW'(r_k);
  assign w_idx_f = AW'(GATE_F * N) + AW'(r_k);
  assign w_idx_g = AW'(GATE_G * N) + AW'(r_k);
  assign w_idx_o = AW'(GATE_O * N) + AW'(r_k);

  lstm_act_unit u_act (
    .i_a_i (A[w_idx_i]),
    .i_a_f (A[w_idx_f]),
    .i_a_g (A[w_idx_g]),
    .i_a_o (A[w_idx_o]),
    .o_act (w_act)
  );

  // c[k] is read here before the same-edge write; each k is visited once.
  assign w_sum = mul_shr(r_act.sf, r_c[r_k1]) + mul_shr(r_act.si, r_act.tg);
  assign w_cn  = sat32(w_sum);

  assign w_last_out = r_vld_pipe[3] && r_last3;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_issue = 1'b1;
        if (r_k == KW'(N-1)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_last_out) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_k1       <= '0;
      r_k2       <= '0;
      r_vld_pipe <= '0;
      r_last3    <= 1'b0;
      r_done     <= 1'b0;
      r_act      <= '0;
      r_cn       <= '0;
      r_so2      <= '0;
      for (int i = 0; i < N; i++) begin
        r_c[i] <= '0;
        r_h[i] <= '0;
      end
    end else begin
      r_vld_pipe <= {r_vld_pipe[2:1], w_issue};
      r_last3    <= r_vld_pipe[2] && (r_k2 == KW'(N-1));
      r_done     <= (r_state == ST_DRAIN) && w_last_out;

      if (r_state == ST_IDLE) r_k <= '0;
      else if (w_issue)       r_k <= r_k + KW'(1);

      if (w_issue) begin
        r_act <= w_act;
        r_k1  <= r_k;
      end

      if (r_vld_pipe[1]) begin
        r_c[r_k1] <= w_cn;
        r_cn      <= w_cn;
        r_so2     <= r_act.so;
        r_k2      <= r_k1;
      end

      if (r_vld_pipe[2]) r_h[r_k2] <= fx_mul(r_so2, htanh(r_cn));

      // Pipeline is empty in IDLE, so the clear never races a unit write.
      if (r_state == ST_IDLE && clear_state)
        for (int i = 0; i < N; i++) r_c[i] <= '0;
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign h    = r_h;
  assign c    = r_c;
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update: table of uniform/ramped passes plus
// restart-while-busy and mid-pass reset sequences.
module tb_lstm_cell_update;
  import lstm_pkg::*;

  localparam int N = 100;

  logic clk = 1'b0;
  logic rst_n;
  fx_t  A [0:4*N-1];
  logic start, clear_state;
  logic busy, done;
  fx_t  h [0:N-1];
  fx_t  c [0:N-1];

  int n_chk  = 0;
  int n_fail = 0;

  lstm_cell_update #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (A),
    .start       (start),
    .clear_state (clear_state),
    .busy        (busy),
    .done        (done),
    .h           (h),
    .c           (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int ai, af, ag, ao, gstep;
    bit clr;
    int c0, cs, h0, hs;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected value for unit k is base + k*step.
  task automatic chk_arrays(input string nm, input int c0, input int cs,
                            input int h0, input int hs);
    int bc, bh, kc, kh;
    bc = 0; bh = 0; kc = -1; kh = -1;
    for (int k = 0; k < N; k++) begin
      if (c[k] !== fx_t'(c0 + k*cs)) begin bc++; if (kc < 0) kc = k; end
      if (h[k] !== fx_t'(h0 + k*hs)) begin bh++; if (kh < 0) kh = k; end
    end
    n_chk += 2;
    if (bc != 0) begin
      n_fail++;
      $display("FAIL %s c: %0d bad units, c[%0d]=%0d expected %0d",
               nm, bc, kc, c[kc], c0 + kc*cs);
    end
    if (bh != 0) begin
      n_fail++;
      $display("FAIL %s h: %0d bad units, h[%0d]=%0d expected %0d",
               nm, bh, kh, h[kh], h0 + kh*hs);
    end
  endtask

  task automatic set_a(input int ai, input int af, input int ag, input int ao,
                       input int gstep);
    for (int k = 0; k < N; k++) begin
      A[k]       = ai;
      A[N+k]     = af;
      A[2*N+k]   = ag + k*gstep;
      A[3*N+k]   = ao;
    end
  endtask

  // Pulses start, then watches a fixed window; restart_at>0 re-pulses start
  // before that edge. lat is the edge index of the first done, -1 if none.
  task automatic do_pass(input string nm, input bit clr, input int restart_at,
                         output int lat, output int ndone);
    clear_state = clr;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    clear_state = 1'b0;
    chk({nm, " busy_after_start"}, busy, 1);
    lat = -1; ndone = 0;
    for (int cyc = 1; cyc <= N + 20; cyc++) begin
      if (cyc == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
    end
  endtask

  initial begin
    int lat, nd;
    tbl[0] = '{"zero",  0,       0,       0,        0,      0,   1'b1, 0,      0,   0,      0};
    tbl[1] = '{"half",  262144, -262144,  32768,    262144, 0,   1'b1, 32768,  0,   32768,  0};
    tbl[2] = '{"acc1",  262144,  262144,  65536,    262144, 0,   1'b1, 65536,  0,   65536,  0};
    tbl[3] = '{"acc2",  262144,  262144,  65536,    262144, 0,   1'b0, 131072, 0,   65536,  0};
    tbl[4] = '{"acc3",  262144,  262144,  65536,    262144, 0,   1'b0, 196608, 0,   65536,  0};
    tbl[5] = '{"clamp", 6553600, 0,      -6553600,  262144, 0,   1'b1, -65536, 0,  -65536,  0};
    tbl[6] = '{"mid",   0,       0,      -32768,    0,      0,   1'b0, -49152, 0,  -24576,  0};
    tbl[7] = '{"ramp",  262144, -262144,  0,        262144, 655, 1'b1, 0,      655, 0,      655};

    rst_n = 1'b0; start = 1'b0; clear_state = 1'b0;
    set_a(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk_arrays("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      set_a(tbl[i].ai, tbl[i].af, tbl[i].ag, tbl[i].ao, tbl[i].gstep);
      do_pass(tbl[i].nm, tbl[i].clr, 0, lat, nd);
      chk({tbl[i].nm, " latency"}, lat, N + 3);
      chk({tbl[i].nm, " done_count"}, nd, 1);
      chk_arrays(tbl[i].nm, tbl[i].c0, tbl[i].cs, tbl[i].h0, tbl[i].hs);
    end

    // Second start mid-pass must not disturb the running pass.
    set_a(262144, -262144, 32768, 262144, 0);
    do_pass("restart", 1'b1, 10, lat, nd);
    chk("restart latency", lat, N + 3);
    chk("restart done_count", nd, 1);
    chk("restart busy_after", busy, 0);
    chk_arrays("restart", 32768, 0, 32768, 0);

    // One-cycle reset at cycle 50 abandons the pass.
    set_a(262144, 262144, 65536, 262144, 0);
    clear_state = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear_state = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk_arrays("midrst", 0, 0, 0, 0);
    nd = 0;
    for (int cyc = 0; cyc < N + 10; cyc++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst no_done", nd, 0);
    do_pass("postrst", 1'b0, 0, lat, nd);
    chk("postrst latency", lat, N + 3);
    chk("postrst done_count", nd, 1);
    chk_arrays("postrst", 65536, 0, 65536, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
